branch_predict_ctrl: RTL and testbench

Dynamic branch predictor and mispredict controller for the RV32I pipeline. Holds a direct-mapped branch target buffer with per-entry 2-bit saturating counters. Supplies a taken/target prediction to IF every cycle. Trains on the resolved outcome produced by the EX-stage branch decision logic, and raises a flush/redirect to the hazard unit on mispredict. Also keeps branch and mispredict statistics counters.

---
 rtl/branch_predict_ctrl_pkg.sv | 24 ++
 rtl/branch_predict_ctrl_if.sv | 32 +++
 rtl/branch_predict_ctrl_btb_table.sv | 61 ++++++
 rtl/branch_predict_ctrl.sv | 143 ++++++++++++++
 tb/tb_branch_predict_ctrl.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/branch_predict_ctrl_pkg.sv
// Shared types and helpers for the branch predictor: counter encodings,
// default table geometry and the saturating counter step.
package branch_predict_ctrl_pkg;

  localparam int INDEX_BITS_DEF = 6;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_e;

  function automatic ctr_e ctr_next(input ctr_e cur, input logic taken);
    case (cur)
      CTR_SNT: ctr_next = taken ? CTR_WNT : CTR_SNT;
      CTR_WNT: ctr_next = taken ? CTR_WT  : CTR_SNT;
      CTR_WT:  ctr_next = taken ? CTR_ST  : CTR_WNT;
      CTR_ST:  ctr_next = taken ? CTR_ST  : CTR_WT;
      default: ctr_next = CTR_WNT;
    endcase
  endfunction

endpackage

// File: rtl/branch_predict_ctrl_if.sv
// Fetch-side prediction, EX-side resolution and statistics signals of the
// branch predictor, bundled for the pipeline and the testbench.
interface branch_predict_ctrl_if;
  logic [31:0] pc_if;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid;
  logic        ex_stall;
  logic [31:0] pc_ex;
  logic        br_ex;
  logic [31:0] br_target_ex;
  logic        pred_taken_ex;
  logic [31:0] pred_target_ex;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [31:0] branch_cnt;
  logic [31:0] mispredict_cnt;

  modport slave (
    input  pc_if, ex_valid, ex_stall, pc_ex, br_ex, br_target_ex,
           pred_taken_ex, pred_target_ex,
    output pred_taken, pred_target, mispredict, redirect_pc,
           branch_cnt, mispredict_cnt
  );

  modport master (
    output pc_if, ex_valid, ex_stall, pc_ex, br_ex, br_target_ex,
           pred_taken_ex, pred_target_ex,
    input  pred_taken, pred_target, mispredict, redirect_pc,
           branch_cnt, mispredict_cnt
  );
endinterface

// File: rtl/branch_predict_ctrl_btb_table.sv
// Direct-mapped BTB storage: asynchronous reset, a combinational fetch read
// port, a combinational EX lookup port and one synchronous write port.
module btb_table
  import branch_predict_ctrl_pkg::*;
#(
  parameter int INDEX_BITS = INDEX_BITS_DEF,
  localparam int TAG_BITS  = 30 - INDEX_BITS,
  localparam int DEPTH     = 1 << INDEX_BITS
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [INDEX_BITS-1:0] i_if_idx,
  output logic                  o_if_valid,
  output logic [TAG_BITS-1:0]   o_if_tag,
  output logic [31:0]           o_if_target,
  output ctr_e                  o_if_ctr,
  input  logic [INDEX_BITS-1:0] i_ex_idx,
  output logic                  o_ex_valid,
  output logic [TAG_BITS-1:0]   o_ex_tag,
  output logic [31:0]           o_ex_target,
  output ctr_e                  o_ex_ctr,
  input  logic                  i_we,
  input  logic [INDEX_BITS-1:0] i_widx,
  input  logic                  i_wvalid,
  input  logic [TAG_BITS-1:0]   i_wtag,
  input  logic [31:0]           i_wtarget,
  input  ctr_e                  i_wctr
);

  logic                r_valid  [DEPTH];
  logic [TAG_BITS-1:0] r_tag    [DEPTH];
  logic [31:0]         r_target [DEPTH];
  ctr_e                r_ctr    [DEPTH];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= {TAG_BITS{1'b0}};
        r_target[i] <= 32'h0000_0000;
        r_ctr[i]    <= CTR_WNT;
      end
    end else if (i_we) begin
      r_valid[i_widx]  <= i_wvalid;
      r_tag[i_widx]    <= i_wtag;
      r_target[i_widx] <= i_wtarget;
      r_ctr[i_widx]    <= i_wctr;
    end
  end

  // Both reads see pre-write contents, so a same-cycle fetch gets the old entry.
  assign o_if_valid  = r_valid[i_if_idx];
  assign o_if_tag    = r_tag[i_if_idx];
  assign o_if_target = r_target[i_if_idx];
  assign o_if_ctr    = r_ctr[i_if_idx];
  assign o_ex_valid  = r_valid[i_ex_idx];
  assign o_ex_tag    = r_tag[i_ex_idx];
  assign o_ex_target = r_target[i_ex_idx];
  assign o_ex_ctr    = r_ctr[i_ex_idx];

endmodule

// File: rtl/branch_predict_ctrl.sv
// Dynamic branch predictor: BTB lookup for fetch, training and mispredict
// redirect from EX, plus branch / mispredict statistics.
module branch_predict_ctrl
  import branch_predict_ctrl_pkg::*;
#(
  parameter int INDEX_BITS = INDEX_BITS_DEF
) (
  input logic                 clk,
  input logic                 rst,
  branch_predict_ctrl_if.slave bus
);

  localparam int TAG_BITS = 30 - INDEX_BITS;

  logic [INDEX_BITS-1:0] w_if_idx;
  logic [TAG_BITS-1:0]   w_if_tag;
  logic [INDEX_BITS-1:0] w_ex_idx;
  logic [TAG_BITS-1:0]   w_ex_tag;
  logic                  w_if_valid_rd;
  logic [TAG_BITS-1:0]   w_if_tag_rd;
  logic [31:0]           w_if_target_rd;
  ctr_e                  w_if_ctr_rd;
  logic                  w_ex_valid_rd;
  logic [TAG_BITS-1:0]   w_ex_tag_rd;
  logic [31:0]           w_ex_target_rd;
  ctr_e                  w_ex_ctr_rd;
  logic                  w_we;
  logic                  w_wvalid;
  logic [31:0]           w_wtarget;
  ctr_e                  w_wctr;
  logic                  w_upd;
  logic                  w_ex_hit;
  logic                  w_pred_taken;
  logic [31:0]           w_pred_target;
  logic                  w_mispredict;
  logic [31:0]           w_redirect_pc;
  logic [31:0]           r_branch_cnt;
  logic [31:0]           r_mispredict_cnt;
  logic                  w_unused_pc_bits;

  assign w_if_idx = bus.pc_if[INDEX_BITS+1:2];
  assign w_if_tag = bus.pc_if[31:INDEX_BITS+2];
  assign w_ex_idx = bus.pc_ex[INDEX_BITS+1:2];
  assign w_ex_tag = bus.pc_ex[31:INDEX_BITS+2];
  assign w_unused_pc_bits = ^bus.pc_if[1:0];

  btb_table #(.INDEX_BITS(INDEX_BITS)) u_btb (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_if_idx    (w_if_idx),
    .o_if_valid  (w_if_valid_rd),
    .o_if_tag    (w_if_tag_rd),
    .o_if_target (w_if_target_rd),
    .o_if_ctr    (w_if_ctr_rd),
    .i_ex_idx    (w_ex_idx),
    .o_ex_valid  (w_ex_valid_rd),
    .o_ex_tag    (w_ex_tag_rd),
    .o_ex_target (w_ex_target_rd),
    .o_ex_ctr    (w_ex_ctr_rd),
    .i_we        (w_we),
    .i_widx      (w_ex_idx),
    .i_wvalid    (w_wvalid),
    .i_wtag      (w_ex_tag),
    .i_wtarget   (w_wtarget),
    .i_wctr      (w_wctr)
  );

  assign w_upd    = bus.ex_valid & ~bus.ex_stall;
  assign w_ex_hit = w_ex_valid_rd & (w_ex_tag_rd == w_ex_tag);

  always_comb begin
    w_pred_taken  = 1'b0;
    w_pred_target = 32'h0000_0000;
    if (w_if_valid_rd && (w_if_tag_rd == w_if_tag) && w_if_ctr_rd[1]) begin
      w_pred_taken  = 1'b1;
      w_pred_target = w_if_target_rd;
    end else begin
      w_pred_taken  = 1'b0;
      w_pred_target = 32'h0000_0000;
    end
  end

  // Hits train in place; only taken misses allocate, evicting any alias.
  always_comb begin
    w_we      = 1'b0;
    w_wvalid  = w_ex_valid_rd;
    w_wtarget = w_ex_target_rd;
    w_wctr    = w_ex_ctr_rd;
    if (w_upd && w_ex_hit) begin
      w_we      = 1'b1;
      w_wvalid  = 1'b1;
      w_wctr    = ctr_next(w_ex_ctr_rd, bus.br_ex);
      w_wtarget = bus.br_ex ? bus.br_target_ex : w_ex_target_rd;
    end else if (w_upd && bus.br_ex) begin
      w_we      = 1'b1;
      w_wvalid  = 1'b1;
      w_wctr    = CTR_WT;
      w_wtarget = bus.br_target_ex;
    end else begin
      w_we      = 1'b0;
    end
  end

  // Reset forces the redirect quiet immediately, even mid-update.
  always_comb begin
    w_mispredict  = 1'b0;
    w_redirect_pc = 32'h0000_0000;
    if (rst || !w_upd) begin
      w_mispredict  = 1'b0;
      w_redirect_pc = 32'h0000_0000;
    end else if (bus.br_ex && (!bus.pred_taken_ex ||
                               (bus.pred_target_ex != bus.br_target_ex))) begin
      w_mispredict  = 1'b1;
      w_redirect_pc = bus.br_target_ex;
    end else if (!bus.br_ex && bus.pred_taken_ex) begin
      w_mispredict  = 1'b1;
      w_redirect_pc = bus.pc_ex + 32'd4;
    end else begin
      w_mispredict  = 1'b0;
      w_redirect_pc = 32'h0000_0000;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_branch_cnt     <= 32'h0000_0000;
      r_mispredict_cnt <= 32'h0000_0000;
    end else if (w_upd) begin
      r_branch_cnt <= r_branch_cnt + 32'd1;
      if (w_mispredict) begin
        r_mispredict_cnt <= r_mispredict_cnt + 32'd1;
      end
    end
  end

  assign bus.pred_taken     = w_pred_taken;
  assign bus.pred_target    = w_pred_target;
  assign bus.mispredict     = w_mispredict;
  assign bus.redirect_pc    = w_redirect_pc;
  assign bus.branch_cnt     = r_branch_cnt;
  assign bus.mispredict_cnt = r_mispredict_cnt;

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Directed bench for branch_predict_ctrl at INDEX_BITS=6 with hand-computed
// expectations for training, aliasing, stall and asynchronous reset.
module tb_branch_predict_ctrl;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_err;

  branch_predict_ctrl_if bus ();

  branch_predict_ctrl #(.INDEX_BITS(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_pred(input string tag, input logic [31:0] pc,
                            input logic exp_taken, input logic [31:0] exp_tgt);
    bus.pc_if = pc;
    #1;
    check_val({tag, "_taken"}, {31'd0, bus.pred_taken}, {31'd0, exp_taken});
    check_val({tag, "_tgt"}, bus.pred_target, exp_tgt);
  endtask

  task automatic check_cnts(input string tag, input logic [31:0] exp_b,
                            input logic [31:0] exp_m);
    check_val({tag, "_bcnt"}, bus.branch_cnt, exp_b);
    check_val({tag, "_mcnt"}, bus.mispredict_cnt, exp_m);
  endtask

  // Drive an EX update at the falling edge and check the combinational redirect.
  task automatic upd_drive(input string tag, input logic [31:0] pc,
                           input logic br, input logic [31:0] tgt,
                           input logic pt, input logic [31:0] ptg,
                           input logic exp_mis, input logic [31:0] exp_redir);
    @(negedge clk);
    bus.ex_valid       = 1'b1;
    bus.ex_stall       = 1'b0;
    bus.pc_ex          = pc;
    bus.br_ex          = br;
    bus.br_target_ex   = tgt;
    bus.pred_taken_ex  = pt;
    bus.pred_target_ex = ptg;
    #1;
    check_val({tag, "_mis"}, {31'd0, bus.mispredict}, {31'd0, exp_mis});
    check_val({tag, "_redir"}, bus.redirect_pc, exp_redir);
  endtask

  task automatic upd_commit();
    @(posedge clk);
    #1;
    bus.ex_valid = 1'b0;
  endtask

  task automatic upd(input string tag, input logic [31:0] pc, input logic br,
                     input logic [31:0] tgt, input logic pt,
                     input logic [31:0] ptg, input logic exp_mis,
                     input logic [31:0] exp_redir);
    upd_drive(tag, pc, br, tgt, pt, ptg, exp_mis, exp_redir);
    upd_commit();
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst = 1'b1;
    bus.pc_if = 32'h100;
    bus.ex_valid = 1'b0;
    bus.ex_stall = 1'b0;
    bus.pc_ex = 32'h0;
    bus.br_ex = 1'b0;
    bus.br_target_ex = 32'h0;
    bus.pred_taken_ex = 1'b0;
    bus.pred_target_ex = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check_pred("rst", 32'h100, 1'b0, 32'h0);
    check_cnts("rst", 32'd0, 32'd0);
    check_val("rst_mis", {31'd0, bus.mispredict}, 32'd0);
    #2 rst = 1'b0;

    upd("cold", 32'h100, 1'b1, 32'h80, 1'b0, 32'h0, 1'b1, 32'h80);
    check_cnts("cold", 32'd1, 32'd1);
    check_pred("cold", 32'h100, 1'b1, 32'h80);

    upd("t1", 32'h100, 1'b1, 32'h80, 1'b1, 32'h80, 1'b0, 32'h0);
    upd("t2", 32'h100, 1'b1, 32'h80, 1'b1, 32'h80, 1'b0, 32'h0);
    check_cnts("st", 32'd3, 32'd1);

    upd("nt1", 32'h100, 1'b0, 32'h80, 1'b1, 32'h80, 1'b1, 32'h104);
    check_pred("nt1", 32'h100, 1'b1, 32'h80);
    upd("nt2", 32'h100, 1'b0, 32'h80, 1'b1, 32'h80, 1'b1, 32'h104);
    check_pred("nt2", 32'h100, 1'b0, 32'h0);
    upd("nt3", 32'h100, 1'b0, 32'h80, 1'b0, 32'h0, 1'b0, 32'h0);
    upd("nt4", 32'h100, 1'b0, 32'h80, 1'b0, 32'h0, 1'b0, 32'h0);
    check_cnts("snt", 32'd7, 32'd3);

    upd("up1", 32'h100, 1'b1, 32'h80, 1'b0, 32'h0, 1'b1, 32'h80);
    check_pred("up1", 32'h100, 1'b0, 32'h0);
    upd("up2", 32'h100, 1'b1, 32'h80, 1'b0, 32'h0, 1'b1, 32'h80);
    check_pred("up2", 32'h100, 1'b1, 32'h80);

    upd("retgt", 32'h100, 1'b1, 32'hC0, 1'b1, 32'h80, 1'b1, 32'hC0);
    check_pred("retgt", 32'h100, 1'b1, 32'hC0);
    check_cnts("retgt", 32'd10, 32'd6);

    upd_drive("alias", 32'h200, 1'b1, 32'h300, 1'b0, 32'h0, 1'b1, 32'h300);
    check_pred("samecyc", 32'h100, 1'b1, 32'hC0);
    upd_commit();
    check_pred("evict", 32'h100, 1'b0, 32'h0);
    check_pred("alloc", 32'h200, 1'b1, 32'h300);

    upd("ntmiss", 32'h500, 1'b0, 32'h900, 1'b0, 32'h0, 1'b0, 32'h0);
    check_pred("ntmiss", 32'h200, 1'b1, 32'h300);
    check_pred("ntmiss_no", 32'h500, 1'b0, 32'h0);

    upd("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h40, 1'b1, 32'h0);
    check_cnts("wrap", 32'd13, 32'd8);

    @(negedge clk);
    bus.ex_valid = 1'b1;
    bus.ex_stall = 1'b1;
    bus.pc_ex = 32'h400;
    bus.br_ex = 1'b1;
    bus.br_target_ex = 32'h440;
    bus.pred_taken_ex = 1'b0;
    bus.pred_target_ex = 32'h0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_val("stall_mis", {31'd0, bus.mispredict}, 32'd0);
      @(negedge clk);
    end
    check_cnts("stall", 32'd13, 32'd8);
    check_pred("stall", 32'h400, 1'b0, 32'h0);
    bus.ex_stall = 1'b0;
    #1;
    check_val("rel_mis", {31'd0, bus.mispredict}, 32'd1);
    check_val("rel_redir", bus.redirect_pc, 32'h440);
    upd_commit();
    check_cnts("rel", 32'd14, 32'd9);
    check_pred("rel", 32'h400, 1'b1, 32'h440);
    check_pred("rel_evict", 32'h200, 1'b0, 32'h0);

    @(negedge clk);
    bus.pc_if = 32'h400;
    bus.ex_valid = 1'b1;
    bus.pc_ex = 32'h400;
    bus.br_ex = 1'b0;
    bus.pred_taken_ex = 1'b1;
    bus.pred_target_ex = 32'h440;
    #1;
    check_val("pre_rst_mis", {31'd0, bus.mispredict}, 32'd1);
    rst = 1'b1;
    #1;
    check_val("arst_taken", {31'd0, bus.pred_taken}, 32'd0);
    check_val("arst_tgt", bus.pred_target, 32'h0);
    check_val("arst_mis", {31'd0, bus.mispredict}, 32'd0);
    check_val("arst_redir", bus.redirect_pc, 32'h0);
    check_cnts("arst", 32'd0, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus.pc_ex = 32'h100;
    bus.br_ex = 1'b1;
    bus.br_target_ex = 32'h80;
    bus.pred_taken_ex = 1'b0;
    bus.pred_target_ex = 32'h0;
    check_pred("post_400", 32'h400, 1'b0, 32'h0);
    check_pred("post_200", 32'h200, 1'b0, 32'h0);
    check_pred("post_100", 32'h100, 1'b0, 32'h0);
    upd_commit();
    check_cnts("first_upd", 32'd1, 32'd1);
    check_pred("first_upd", 32'h100, 1'b1, 32'h80);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
